obj_alloc_unit: RTL and testbench

OBJ_ALLOC_UNIT -- requirements
Module: obj_alloc_unit

---
 rtl/obj_pkg.sv | 23 ++
 rtl/obj_alloc_if.sv | 36 +++
 rtl/obj_slot_table.sv | 66 ++++++
 rtl/obj_alloc_unit.sv | 137 +++++++++++++
 tb/tb_obj_alloc_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obj_pkg.sv
// Shared types and sizes for the object slot allocator.
// Optional build macro: OBJ_ALLOC_ROUND_ROBIN_EN (see obj_alloc_unit.sv).
package obj_pkg;

    localparam int OBJ_SLOTS   = 32;
    localparam int OBJ_NUM_W   = 5;
    localparam int PT_W        = 3;
    localparam int VMEM_ADDR_W = 8;
    localparam int CNT_W       = OBJ_NUM_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        GRANT  = 2'd2,
        REF    = 2'd3
    } obj_state_e;

    // Each slot owns an 8-entry block of video memory.
    function automatic logic [VMEM_ADDR_W-1:0] slot_to_addr(input logic [OBJ_NUM_W-1:0] slot);
        return {slot, 3'b000};
    endfunction

endpackage

// File: rtl/obj_alloc_if.sv
// Command/response bundle between a requester (master) and obj_alloc_unit (slave).
interface obj_alloc_if;
    import obj_pkg::*;

    // Commands are single-cycle pulses, taken only while busy is low; anything
    // pulsed while busy is dropped. addr_vld is a one-cycle pulse with no
    // back-pressure: addr_out/max_point_cnt/new_obj_num qualify only with it.
    logic                   crt_obj;
    logic                   del_obj;
    logic                   del_all;
    logic                   ref_addr;
    logic [OBJ_NUM_W-1:0]   obj_num_in;
    logic [PT_W-1:0]        pts_in;

    logic [VMEM_ADDR_W-1:0] addr_out;
    logic                   addr_vld;
    logic [PT_W-1:0]        max_point_cnt;
    logic [OBJ_NUM_W-1:0]   new_obj_num;
    logic                   obj_mem_full;
    logic                   ref_err;
    logic                   busy;
    obj_state_e             dbg_state;

    modport master (
        output crt_obj, del_obj, del_all, ref_addr, obj_num_in, pts_in,
        input  addr_out, addr_vld, max_point_cnt, new_obj_num,
        input  obj_mem_full, ref_err, busy, dbg_state
    );

    modport slave (
        input  crt_obj, del_obj, del_all, ref_addr, obj_num_in, pts_in,
        output addr_out, addr_vld, max_point_cnt, new_obj_num,
        output obj_mem_full, ref_err, busy, dbg_state
    );

endinterface

// File: rtl/obj_slot_table.sv
// Per-slot valid bits and point indices plus the live-object count and full flag.
module obj_slot_table
    import obj_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_all_i,
    input  logic                 clr_en_i,
    input  logic [OBJ_NUM_W-1:0] clr_idx_i,
    input  logic                 set_en_i,
    input  logic [OBJ_NUM_W-1:0] set_idx_i,
    input  logic [PT_W-1:0]      set_pts_i,
    input  logic [OBJ_NUM_W-1:0] rd_idx_i,
    output logic [OBJ_SLOTS-1:0] valid_o,
    output logic [PT_W-1:0]      rd_pts_o,
    output logic                 full_o
);

    logic [OBJ_SLOTS-1:0] valid_q, valid_d;
    logic [PT_W-1:0]      pts_q [OBJ_SLOTS];
    logic [PT_W-1:0]      pts_d [OBJ_SLOTS];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 full_q, full_d;

    // Only one update per cycle; the guards keep obj_cnt in step with the valid bits.
    always_comb begin
        valid_d = valid_q;
        pts_d   = pts_q;
        cnt_d   = cnt_q;
        if (clr_all_i) begin
            valid_d = '0;
            cnt_d   = '0;
        end else if (clr_en_i && valid_q[clr_idx_i]) begin
            valid_d[clr_idx_i] = 1'b0;
            cnt_d              = cnt_q - CNT_W'(1);
        end else if (set_en_i && !valid_q[set_idx_i]) begin
            valid_d[set_idx_i] = 1'b1;
            pts_d[set_idx_i]   = set_pts_i;
            cnt_d              = cnt_q + CNT_W'(1);
        end
        full_d = (cnt_d == CNT_W'(OBJ_SLOTS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            for (int i = 0; i < OBJ_SLOTS; i++) begin
                pts_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            for (int i = 0; i < OBJ_SLOTS; i++) begin
                pts_q[i] <= pts_d[i];
            end
        end
    end

    assign valid_o  = valid_q;
    assign rd_pts_o = pts_q[rd_idx_i];
    assign full_o   = full_q;

endmodule

// File: rtl/obj_alloc_unit.sv
// Object slot allocator: create/delete/lookup of 32 video-memory object slots.
// Define OBJ_ALLOC_ROUND_ROBIN_EN to resume the free-slot scan after the last grant.
module obj_alloc_unit
    import obj_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    obj_alloc_if.slave bus
);

    obj_state_e           state_q, state_d;
    logic [OBJ_NUM_W-1:0] scan_ptr_q, scan_ptr_d;
    logic [PT_W-1:0]      pts_lat_q, pts_lat_d;
    logic [OBJ_NUM_W-1:0] ref_num_q, ref_num_d;
    logic                 del_err_q, del_err_d;

    logic                 tbl_clr_all, tbl_clr_en, tbl_set_en;
    logic [OBJ_SLOTS-1:0] tbl_valid;
    logic [PT_W-1:0]      tbl_rd_pts;
    logic                 tbl_full;

    logic                   addr_vld;
    logic [VMEM_ADDR_W-1:0] addr_out;
    logic [PT_W-1:0]        max_point_cnt;
    logic [OBJ_NUM_W-1:0]   new_obj_num;
    logic                   ref_miss;

    obj_slot_table u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_all_i (tbl_clr_all),
        .clr_en_i  (tbl_clr_en),
        .clr_idx_i (bus.obj_num_in),
        .set_en_i  (tbl_set_en),
        .set_idx_i (scan_ptr_q),
        .set_pts_i (pts_lat_q),
        .rd_idx_i  (ref_num_q),
        .valid_o   (tbl_valid),
        .rd_pts_o  (tbl_rd_pts),
        .full_o    (tbl_full)
    );

    always_comb begin
        state_d       = state_q;
        scan_ptr_d    = scan_ptr_q;
        pts_lat_d     = pts_lat_q;
        ref_num_d     = ref_num_q;
        del_err_d     = 1'b0;
        tbl_clr_all   = 1'b0;
        tbl_clr_en    = 1'b0;
        tbl_set_en    = 1'b0;
        addr_vld      = 1'b0;
        addr_out      = '0;
        max_point_cnt = '0;
        new_obj_num   = '0;
        ref_miss      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.del_all) begin
                    tbl_clr_all = 1'b1;
                end else if (bus.del_obj) begin
                    if (tbl_valid[bus.obj_num_in]) tbl_clr_en = 1'b1;
                    else                           del_err_d  = 1'b1;
                end else if (bus.crt_obj) begin
                    // A full table swallows the create, and any lower-priority ref with it.
                    if (!tbl_full) begin
                        pts_lat_d = bus.pts_in;
                        state_d   = SEARCH;
`ifndef OBJ_ALLOC_ROUND_ROBIN_EN
                        scan_ptr_d = '0;
`endif
                    end
                end else if (bus.ref_addr) begin
                    ref_num_d = bus.obj_num_in;
                    state_d   = REF;
                end
            end

            SEARCH: begin
                // The pointer stays on the free slot so GRANT can use it directly.
                if (!tbl_valid[scan_ptr_q]) state_d    = GRANT;
                else                        scan_ptr_d = scan_ptr_q + OBJ_NUM_W'(1);
            end

            GRANT: begin
                tbl_set_en    = 1'b1;
                addr_vld      = 1'b1;
                addr_out      = slot_to_addr(scan_ptr_q);
                new_obj_num   = scan_ptr_q;
                max_point_cnt = pts_lat_q;
                state_d       = IDLE;
`ifdef OBJ_ALLOC_ROUND_ROBIN_EN
                scan_ptr_d = scan_ptr_q + OBJ_NUM_W'(1);
`endif
            end

            REF: begin
                // Lookups always answer; a miss is flagged rather than stalled.
                // new_obj_num only reports creations, so it stays 0 here.
                addr_vld      = 1'b1;
                addr_out      = slot_to_addr(ref_num_q);
                ref_miss      = !tbl_valid[ref_num_q];
                max_point_cnt = ref_miss ? '0 : tbl_rd_pts;
                state_d       = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scan_ptr_q <= '0;
            pts_lat_q  <= '0;
            ref_num_q  <= '0;
            del_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_ptr_q <= scan_ptr_d;
            pts_lat_q  <= pts_lat_d;
            ref_num_q  <= ref_num_d;
            del_err_q  <= del_err_d;
        end
    end

    assign bus.addr_vld      = addr_vld;
    assign bus.addr_out      = addr_out;
    assign bus.max_point_cnt = max_point_cnt;
    assign bus.new_obj_num   = new_obj_num;
    assign bus.ref_err       = del_err_q | ref_miss;
    assign bus.obj_mem_full  = tbl_full;
    assign bus.busy          = (state_q != IDLE);
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_obj_alloc_unit.sv
// Directed bench for obj_alloc_unit with a slot-level reference model and per-cycle compare.
module tb_obj_alloc_unit;
    import obj_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obj_alloc_if bus ();

    obj_alloc_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       vld;
        logic [7:0] addr;
        logic [2:0] mpc;
        logic [4:0] nnum;
        logic       err;
        logic       busy;
        logic       full;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: which slots hold objects, their point indices, scan start.
    logic       m_valid [32];
    logic [2:0] m_pts   [32];
    int         m_cnt = 0;
    int         m_rr  = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;
    logic [7:0] last_addr = '0;
    logic [2:0] last_mpc  = '0;
    logic [4:0] last_nnum = '0;
    logic       last_err  = 1'b0;
    bit         run_cmp   = 1'b1;

    function automatic logic m_full();
        return (m_cnt == 32);
    endfunction

    function automatic exp_t mk(input logic vld, input logic [7:0] addr, input logic [2:0] mpc,
                                input logic [4:0] nnum, input logic err, input logic busy,
                                input logic full);
        exp_t e;
        e.vld = vld; e.addr = addr; e.mpc = mpc; e.nnum = nnum;
        e.err = err; e.busy = busy; e.full = full;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_pts[i]   = '0;
        end
        m_cnt = 0;
        m_rr  = 0;
    endfunction

    // Queue the per-cycle outputs a command must produce and update the model.
    function automatic void model_apply(input logic c, input logic d, input logic da, input logic r,
                                        input int n, input logic [2:0] p);
        int start;
        int k;
        int s;
        if (da) begin
            for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
            m_cnt = 0;
        end else if (d) begin
            if (m_valid[n]) begin
                m_valid[n] = 1'b0;
                m_cnt--;
            end else begin
                exp_q.push_back(mk(1'b0, 8'd0, 3'd0, 5'd0, 1'b1, 1'b0, m_full()));
            end
        end else if (c) begin
            if (!m_full()) begin
`ifdef OBJ_ALLOC_ROUND_ROBIN_EN
                start = m_rr;
`else
                start = 0;
`endif
                s = start;
                for (k = 0; k < 32; k++) begin
                    s = (start + k) % 32;
                    if (!m_valid[s]) break;
                end
                for (int i = 0; i <= k; i++)
                    exp_q.push_back(mk(1'b0, 8'd0, 3'd0, 5'd0, 1'b0, 1'b1, m_full()));
                exp_q.push_back(mk(1'b1, 8'(s * 8), p, 5'(s), 1'b0, 1'b1, m_full()));
                m_valid[s] = 1'b1;
                m_pts[s]   = p;
                m_cnt++;
                m_rr = (s + 1) % 32;
            end
        end else if (r) begin
            exp_q.push_back(mk(1'b1, 8'(n * 8), m_valid[n] ? m_pts[n] : 3'd0, 5'd0,
                               !m_valid[n], 1'b1, m_full()));
        end
    endfunction

    task automatic clear_inputs();
        bus.crt_obj    = 1'b0;
        bus.del_obj    = 1'b0;
        bus.del_all    = 1'b0;
        bus.ref_addr   = 1'b0;
        bus.obj_num_in = '0;
        bus.pts_in     = '0;
    endtask

    task automatic cmd(input logic c, input logic d, input logic da, input logic r,
                       input int n, input logic [2:0] p, input bit inject);
        @(negedge clk);
        bus.crt_obj    = c;
        bus.del_obj    = d;
        bus.del_all    = da;
        bus.ref_addr   = r;
        bus.obj_num_in = 5'(n);
        bus.pts_in     = p;
        model_apply(c, d, da, r, n, p);
        @(negedge clk);
        clear_inputs();
        if (inject) begin
            bus.del_all    = 1'b1;
            bus.ref_addr   = 1'b1;
            bus.obj_num_in = 5'(n);
            @(negedge clk);
            clear_inputs();
        end
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic crt(input logic [2:0] p);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 0, p, 1'b0);
    endtask

    task automatic del(input int n);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, n, 3'd0, 1'b0);
    endtask

    task automatic lookup(input int n);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, n, 3'd0, 1'b0);
    endtask

    // Per-cycle comparison against the model.
    initial begin
        exp_t e;
        exp_t a;
        while (run_cmp) begin
            @(posedge clk);
            #1;
            if (!run_cmp) break;
            e = mk(1'b0, 8'd0, 3'd0, 5'd0, 1'b0, 1'b0, m_full());
            if (exp_q.size() != 0) e = exp_q.pop_front();
            a = mk(bus.addr_vld, bus.addr_out, bus.max_point_cnt, bus.new_obj_num,
                   bus.ref_err, bus.busy, bus.obj_mem_full);
            check("cycle_outputs", 32'(a), 32'(e));
            if (bus.addr_vld) begin
                vld_cnt++;
                last_addr = bus.addr_out;
                last_mpc  = bus.max_point_cnt;
                last_nnum = bus.new_obj_num;
                last_err  = bus.ref_err;
            end
        end
    end

    initial begin
        int snap;
        int last_slot;
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_vld", 32'(bus.addr_vld), 32'd0);
        check("reset_full", 32'(bus.obj_mem_full), 32'd0);
        check("reset_addr", 32'(bus.addr_out), 32'd0);
        rst_n = 1'b1;

        // First create lands in slot 0 at base address 0.
        crt(3'd5);
        check("first_nnum", 32'(last_nnum), 32'd0);
        check("first_addr", 32'(last_addr), 32'h00);
        check("first_mpc", 32'(last_mpc), 32'd5);
        check("first_vld_cnt", 32'(vld_cnt), 32'd1);

        for (int i = 1; i < 32; i++) crt(3'((i + 1) % 8));
        check("full_after_32", 32'(bus.obj_mem_full), 32'd1);
        check("grants_32", 32'(vld_cnt), 32'd32);

        crt(3'd2);
        check("create_when_full_vld", 32'(vld_cnt), 32'd32);
        check("create_when_full_busy", 32'(bus.busy), 32'd0);

        lookup(3);
        check("ref3_addr", 32'(last_addr), 32'h18);
        check("ref3_mpc", 32'(last_mpc), 32'd4);
        check("ref3_err", 32'(last_err), 32'd0);

        del(7);
        crt(3'd6);
        check("regrant7_nnum", 32'(last_nnum), 32'd7);
        check("regrant7_addr", 32'(last_addr), 32'h38);
        check("regrant7_mpc", 32'(last_mpc), 32'd6);

        // Two holes: the scan start decides which one each create takes.
        del(2);
        del(9);
        crt(3'd1);
`ifdef OBJ_ALLOC_ROUND_ROBIN_EN
        check("hole_first", 32'(last_nnum), 32'd9);
`else
        check("hole_first", 32'(last_nnum), 32'd2);
`endif
        crt(3'd3);
`ifdef OBJ_ALLOC_ROUND_ROBIN_EN
        check("hole_wrap", 32'(last_nnum), 32'd2);
`else
        check("hole_wrap", 32'(last_nnum), 32'd9);
`endif

        del(9);
        lookup(9);
        check("ref9_addr", 32'(last_addr), 32'h48);
        check("ref9_mpc", 32'(last_mpc), 32'd0);
        check("ref9_err", 32'(last_err), 32'd1);
        del(9);

        // del_all/ref pulsed during SEARCH must be ignored.
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 9, 3'd7, 1'b1);
        check("busy_ignore_nnum", 32'(last_nnum), 32'd9);
        check("busy_ignore_full", 32'(bus.obj_mem_full), 32'd1);

        snap = vld_cnt;
        cmd(1'b1, 1'b0, 1'b1, 1'b0, 0, 3'd3, 1'b0);
        check("delall_wins_full", 32'(bus.obj_mem_full), 32'd0);
        check("delall_wins_vld", 32'(vld_cnt), 32'(snap));
        lookup(3);
        check("cleared_ref_err", 32'(last_err), 32'd1);

        crt(3'd4);
`ifdef OBJ_ALLOC_ROUND_ROBIN_EN
        last_slot = 10;
`else
        last_slot = 0;
`endif
        check("after_clear_nnum", 32'(last_nnum), 32'(last_slot));

        // Reset while SEARCH is in progress: no grant, table empty.
        @(negedge clk);
        bus.crt_obj = 1'b1;
        bus.pts_in  = 3'd5;
        model_apply(1'b1, 1'b0, 1'b0, 1'b0, 0, 3'd5);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        snap = vld_cnt;
        @(negedge clk);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_vld", 32'(bus.addr_vld), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset_no_grant", 32'(vld_cnt), 32'(snap));
        check("midreset_full", 32'(bus.obj_mem_full), 32'd0);
        lookup(last_slot);
        check("midreset_ref_err", 32'(last_err), 32'd1);
        crt(3'd1);
        check("midreset_next_nnum", 32'(last_nnum), 32'd0);

        repeat (2) @(negedge clk);
        run_cmp = 1'b0;
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
